// File: rtl/lcd_layer_scanner.sv
// Multi-layer raster timing generator: produces panel syncs, display enable
// and pixel coordinates, and for each sprite window a hit flag, a linear ROM
// address and a priority-resolved top layer, all LAT cycles ahead of display.
module lcd_layer_scanner #(
  parameter int H_SYNC  = 136,
  parameter int H_BACK  = 160,
  parameter int H_DISP  = 1024,
  parameter int H_FRONT = 24,
  parameter int V_SYNC  = 6,
  parameter int V_BACK  = 29,
  parameter int V_DISP  = 768,
  parameter int V_FRONT = 3,
  parameter int N_LAYER = 4,
  parameter int LAT     = 2,
  parameter int AW      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_wr,
  input  logic [2:0]             cfg_sel,
  input  logic                   cfg_en,
  input  logic [11:0]            cfg_x,
  input  logic [11:0]            cfg_y,
  input  logic [11:0]            cfg_w,
  input  logic [11:0]            cfg_h,
  output logic                   lcd_hs,
  output logic                   lcd_vs,
  output logic                   lcd_de,
  output logic                   frame_start,
  output logic [11:0]            req_x,
  output logic [11:0]            req_y,
  output logic [N_LAYER-1:0]     layer_hit,
  output logic [N_LAYER*AW-1:0]  layer_addr,
  output logic                   top_valid,
  output logic [2:0]             top_idx
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_ACT   = H_SYNC + H_BACK;  // first displayed column
  localparam int V_ACT   = V_SYNC + V_BACK;  // first displayed line
  localparam int H_REQ   = H_ACT - LAT;      // first requested column

  typedef struct packed {
    logic        en;
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] w;
    logic [11:0] h;
  } win_cfg_t;

  logic [11:0]           hcnt;
  logic [11:0]           vcnt;
  win_cfg_t              shadow_q [N_LAYER];
  win_cfg_t              active_q [N_LAYER];

  logic                  v_in;
  logic                  disp_c;
  logic                  req_c;
  logic                  req_last;
  logic [11:0]           rx_c;
  logic [11:0]           ry_c;
  logic [N_LAYER-1:0]    hit_c;
  logic [N_LAYER-1:0]    row_c;
  logic [N_LAYER*AW-1:0] addr_c;
  logic [2:0]            top_idx_c;

  // Raster position: hcnt sweeps each line, vcnt steps at the end of a line.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; a blocking = here would chain hcnt into vcnt's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == 12'(H_TOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == 12'(V_TOTAL - 1)) ? '0 : vcnt + 12'd1;
    end else begin
      hcnt <= hcnt + 12'd1;
    end
  end

  // Decode display and request regions from the current raster position.
  // NOTE: every always_comb output gets a value on every path (defaults or
  // full if/else), otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    v_in     = (vcnt >= 12'(V_ACT)) && (vcnt < 12'(V_ACT + V_DISP));
    disp_c   = v_in && (hcnt >= 12'(H_ACT)) && (hcnt < 12'(H_ACT + H_DISP));
    req_c    = v_in && (hcnt >= 12'(H_REQ)) && (hcnt < 12'(H_REQ + H_DISP));
    req_last = v_in && (hcnt == 12'(H_REQ + H_DISP - 1));
    rx_c     = req_c ? hcnt - 12'(H_REQ) : '0;
    ry_c     = req_c ? vcnt - 12'(V_ACT) : '0;
  end

  // Shadow writes at any time; shadows move to the active set as a frame
  // begins, so a write in that very cycle only reaches the shadow.
  // NOTE: these small config arrays are real registers and are reset, since
  // the enable bits gate the hit logic from the first frame on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LAYER; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_LAYER; i++) begin
        if (frame_start) active_q[i] <= shadow_q[i];
        if (cfg_wr && (cfg_sel == 3'(i)))
          shadow_q[i] <= '{en: cfg_en, x: cfg_x, y: cfg_y, w: cfg_w, h: cfg_h};
      end
    end
  end

  for (genvar i = 0; i < N_LAYER; i++) begin : g_layer
    logic [12:0]   x_end;
    logic [12:0]   y_end;
    logic          in_x;
    logic          in_y;
    logic [AW-1:0] row_base;

    // 13-bit window ends so a window reaching past 4095 never wraps to 0.
    assign x_end = {1'b0, active_q[i].x} + {1'b0, active_q[i].w};
    assign y_end = {1'b0, active_q[i].y} + {1'b0, active_q[i].h};
    assign in_x  = (rx_c >= active_q[i].x) && ({1'b0, rx_c} < x_end);
    assign in_y  = (ry_c >= active_q[i].y) && ({1'b0, ry_c} < y_end);

    assign hit_c[i] = req_c && active_q[i].en && (active_q[i].w != '0) &&
                      (active_q[i].h != '0) && in_x && in_y;
    assign row_c[i] = req_last && in_y;
    assign addr_c[i*AW +: AW] = hit_c[i] ? row_base + AW'(rx_c - active_q[i].x) : '0;

    // Row base accumulates w per window row, replacing (req_y-Y)*w.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        row_base <= '0;
      end else if (frame_start) begin
        row_base <= '0;
      end else if (row_c[i]) begin
        row_base <= row_base + AW'(active_q[i].w);
      end
    end
  end

  // Highest-index hitting layer wins; 0 when nothing hits.
  always_comb begin
    top_idx_c = '0;
    for (int i = 0; i < N_LAYER; i++) begin
      if (hit_c[i]) top_idx_c = 3'(i);
    end
  end

  // Register every output one cycle behind the raster position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_hs      <= 1'b1;
      lcd_vs      <= 1'b1;
      lcd_de      <= 1'b0;
      frame_start <= 1'b0;
      req_x       <= '0;
      req_y       <= '0;
      layer_hit   <= '0;
      layer_addr  <= '0;
      top_valid   <= 1'b0;
      top_idx     <= '0;
    end else begin
      lcd_hs      <= (hcnt >= 12'(H_SYNC));
      lcd_vs      <= (vcnt >= 12'(V_SYNC));
      lcd_de      <= disp_c;
      frame_start <= (hcnt == '0) && (vcnt == '0);
      req_x       <= rx_c;
      req_y       <= ry_c;
      layer_hit   <= hit_c;
      layer_addr  <= addr_c;
      top_valid   <= |hit_c;
      top_idx     <= top_idx_c;
    end
  end

endmodule

// File: tb/tb_lcd_layer_scanner.sv
// Self-checking bench for lcd_layer_scanner on a tiny 22x12 raster with two
// layers. A frame-position model predicts every output each cycle; directed
// scenarios add hand-computed per-frame totals and address sequences.
module tb_lcd_layer_scanner;

  localparam int H_SYNC = 2, H_BACK = 3, H_DISP = 16, H_FRONT = 1;
  localparam int V_SYNC = 1, V_BACK = 2, V_DISP = 8,  V_FRONT = 1;
  localparam int N_LAYER = 2, LAT = 2, AW = 8;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int FRAME   = H_TOTAL * V_TOTAL;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cfg_wr = 1'b0;
  logic [2:0]            cfg_sel = '0;
  logic                  cfg_en = 1'b0;
  logic [11:0]           cfg_x = '0, cfg_y = '0, cfg_w = '0, cfg_h = '0;
  logic                  lcd_hs, lcd_vs, lcd_de, frame_start;
  logic [11:0]           req_x, req_y;
  logic [N_LAYER-1:0]    layer_hit;
  logic [N_LAYER*AW-1:0] layer_addr;
  logic                  top_valid;
  logic [2:0]            top_idx;

  lcd_layer_scanner #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_DISP(H_DISP), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_DISP(V_DISP), .V_FRONT(V_FRONT),
    .N_LAYER(N_LAYER), .LAT(LAT), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel),
    .cfg_en(cfg_en), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .frame_start(frame_start),
    .req_x(req_x), .req_y(req_y), .layer_hit(layer_hit), .layer_addr(layer_addr),
    .top_valid(top_valid), .top_idx(top_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit en; int x; int y; int w; int h; } win_t;
  win_t sh [N_LAYER];
  win_t ac [N_LAYER];
  int   pos = 0;  // frame position (cycle index) of the current clock cycle

  bit                  e_hs = 1, e_vs = 1, e_de = 0, e_fs = 0, e_tv = 0;
  int                  e_rx = 0, e_ry = 0, e_ti = 0;
  bit [N_LAYER-1:0]    e_hit = '0;
  bit [N_LAYER*AW-1:0] e_addr = '0;

  task automatic model_reset();
    pos = 0;
    e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0; e_tv = 0;
    e_rx = 0; e_ry = 0; e_ti = 0; e_hit = '0; e_addr = '0;
    for (int i = 0; i < N_LAYER; i++) begin
      sh[i] = '{0, 0, 0, 0, 0};
      ac[i] = '{0, 0, 0, 0, 0};
    end
  endtask

  // Outputs after this edge describe the position of the cycle just ending.
  task automatic model_step();
    int h = pos % H_TOTAL;
    int v = pos / H_TOTAL;
    bit vd = (v >= V_SYNC + V_BACK) && (v < V_SYNC + V_BACK + V_DISP);
    bit rq = vd && (h >= H_SYNC + H_BACK - LAT) && (h < H_SYNC + H_BACK - LAT + H_DISP);
    int rx = rq ? h - (H_SYNC + H_BACK - LAT) : 0;
    int ry = rq ? v - (V_SYNC + V_BACK) : 0;
    e_hs = (h >= H_SYNC);
    e_vs = (v >= V_SYNC);
    e_de = vd && (h >= H_SYNC + H_BACK) && (h < H_SYNC + H_BACK + H_DISP);
    e_fs = (pos == 0);
    e_rx = rx; e_ry = ry;
    e_hit = '0; e_addr = '0; e_tv = 0; e_ti = 0;
    for (int i = 0; i < N_LAYER; i++) begin
      if (rq && ac[i].en && ac[i].w > 0 && ac[i].h > 0 &&
          rx >= ac[i].x && rx < ac[i].x + ac[i].w &&
          ry >= ac[i].y && ry < ac[i].y + ac[i].h) begin
        e_hit[i] = 1'b1;
        e_addr[i*AW +: AW] = AW'(((ry - ac[i].y) * ac[i].w + (rx - ac[i].x)) % (1 << AW));
        e_tv = 1;
        e_ti = i;
      end
    end
    if (pos == 1) begin
      for (int i = 0; i < N_LAYER; i++) ac[i] = sh[i];
    end
    if (cfg_wr && cfg_sel < 3'(N_LAYER))
      sh[cfg_sel] = '{bit'(cfg_en), int'(cfg_x), int'(cfg_y), int'(cfg_w), int'(cfg_h)};
    pos = (pos + 1) % FRAME;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    check("lcd_hs",      lcd_hs,      e_hs);
    check("lcd_vs",      lcd_vs,      e_vs);
    check("lcd_de",      lcd_de,      e_de);
    check("frame_start", frame_start, e_fs);
    check("req_x",       req_x,       e_rx);
    check("req_y",       req_y,       e_ry);
    check("layer_hit",   layer_hit,   e_hit);
    check("layer_addr",  layer_addr,  e_addr);
    check("top_valid",   top_valid,   e_tv);
    check("top_idx",     top_idx,     e_ti);
  end

  // ---------------- per-frame statistics ----------------
  int s_fs, s_hs, s_vs, s_de, s_tv, s_top1, seq_err, lag_err;
  int s_hit [N_LAYER];
  int f_x [N_LAYER];
  int f_y [N_LAYER];
  int q1 [$];

  task automatic collect_frame();
    bit hd1 = 0, hd2 = 0;
    int next0 = 0;
    s_fs = 0; s_hs = 0; s_vs = 0; s_de = 0; s_tv = 0; s_top1 = 0;
    seq_err = 0; lag_err = 0;
    q1.delete();
    for (int i = 0; i < N_LAYER; i++) begin
      s_hit[i] = 0; f_x[i] = -1; f_y[i] = -1;
    end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      s_fs += int'(frame_start);
      s_hs += int'(!lcd_hs);
      s_vs += int'(!lcd_vs);
      s_de += int'(lcd_de);
      s_tv += int'(top_valid);
      if (top_valid && top_idx == 3'd1) s_top1++;
      if (hd2 && !lcd_de) lag_err++;
      hd2 = hd1;
      hd1 = |layer_hit;
      for (int i = 0; i < N_LAYER; i++) begin
        if (layer_hit[i]) begin
          s_hit[i]++;
          if (f_x[i] < 0) begin
            f_x[i] = int'(req_x);
            f_y[i] = int'(req_y);
          end
        end
      end
      if (layer_hit[0]) begin
        if (layer_addr[AW-1:0] != next0[AW-1:0]) seq_err++;
        next0++;
      end
      if (layer_hit[1]) q1.push_back(int'(layer_addr[2*AW-1:AW]));
    end
  endtask

  task automatic wait_fs(output int cycles);
    cycles = -1;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      @(negedge clk);
      if (frame_start) begin
        cycles = k;
        break;
      end
    end
    if (cycles < 0) check("wait_frame_start_timeout", 0, 1);
  endtask

  // Called at a falling edge; the write is taken on the next rising edge.
  task automatic cfg_write(input int sel, input bit en, input int x, input int y,
                           input int w, input int h);
    cfg_wr = 1'b1; cfg_sel = 3'(sel); cfg_en = en;
    cfg_x = 12'(x); cfg_y = 12'(y); cfg_w = 12'(w); cfg_h = 12'(h);
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int hit_seen;
    repeat (3) @(negedge clk);
    check("rst_hs", lcd_hs, 1);
    check("rst_vs", lcd_vs, 1);
    check("rst_fs", frame_start, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("fs_after_release", frame_start, 1);
    wait_fs(gap);
    check("frame_period", gap, FRAME);

    // free run with no layers enabled
    collect_frame();
    check("free_fs_count", s_fs, 1);
    check("free_hs_low", s_hs, 2 * V_TOTAL);
    check("free_vs_low", s_vs, 22);
    check("free_de_count", s_de, 128);
    check("free_hits0", s_hit[0], 0);
    check("free_hits1", s_hit[1], 0);

    // single window, written mid-frame, visible from the next frame
    repeat (5) @(negedge clk);
    cfg_write(0, 1, 4, 2, 4, 3);
    wait_fs(gap);
    collect_frame();
    check("l0_hits", s_hit[0], 12);
    check("l0_addr_seq_err", seq_err, 0);
    check("l0_lag_err", lag_err, 0);
    check("l0_first_x", f_x[0], 4);
    check("l0_first_y", f_y[0], 2);

    // clipped window on layer 1
    repeat (5) @(negedge clk);
    cfg_write(0, 0, 0, 0, 0, 0);
    cfg_write(1, 1, 14, 6, 4, 4);
    wait_fs(gap);
    collect_frame();
    check("clip_hits0", s_hit[0], 0);
    check("clip_hits1", s_hit[1], 4);
    check("clip_first_x", f_x[1], 14);
    check("clip_first_y", f_y[1], 6);
    check("clip_lag_err", lag_err, 0);
    check("clip_addr_count", q1.size(), 4);
    if (q1.size() == 4) begin
      check("clip_addr0", q1[0], 0);
      check("clip_addr1", q1[1], 1);
      check("clip_addr2", q1[2], 4);
      check("clip_addr3", q1[3], 5);
    end

    // overlapping windows and priority
    repeat (5) @(negedge clk);
    cfg_write(0, 1, 0, 0, 16, 8);
    cfg_write(1, 1, 2, 2, 2, 2);
    wait_fs(gap);
    collect_frame();
    check("ovl_top_valid", s_tv, 128);
    check("ovl_top1", s_top1, 4);
    check("ovl_hits0", s_hit[0], 128);
    check("ovl_hits1", s_hit[1], 4);
    check("ovl_seq_err", seq_err, 0);
    check("ovl_first1_x", f_x[1], 2);

    // config race: mid-frame write, then a write in the frame_start cycle
    repeat (5) @(negedge clk);
    cfg_write(1, 0, 0, 0, 0, 0);
    cfg_write(0, 1, 8, 0, 4, 1);
    wait_fs(gap);
    cfg_write(0, 1, 12, 0, 4, 1);
    collect_frame();
    check("race_f1_hits", s_hit[0], 4);
    check("race_f1_x", f_x[0], 8);
    collect_frame();
    check("race_f2_hits", s_hit[0], 4);
    check("race_f2_x", f_x[0], 12);

    // zero width never hits
    repeat (5) @(negedge clk);
    cfg_write(0, 1, 4, 2, 0, 3);
    wait_fs(gap);
    collect_frame();
    check("w0_hits", s_hit[0], 0);
    check("w0_top_valid", s_tv, 0);

    // reset in the middle of a line while a window is hitting
    repeat (5) @(negedge clk);
    cfg_write(0, 1, 4, 2, 4, 3);
    wait_fs(gap);
    hit_seen = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      if (layer_hit[0]) begin
        hit_seen = 1;
        break;
      end
    end
    check("hit_before_reset", hit_seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_hs", lcd_hs, 1);
    check("mid_rst_vs", lcd_vs, 1);
    check("mid_rst_de", lcd_de, 0);
    check("mid_rst_req_x", req_x, 0);
    check("mid_rst_hit", layer_hit, 0);
    check("mid_rst_addr", layer_addr, 0);
    check("mid_rst_tv", top_valid, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("fs_after_mid_reset", frame_start, 1);
    collect_frame();
    check("post_rst_hits0", s_hit[0], 0);
    check("post_rst_de", s_de, 128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
